serial_addsub: RTL and testbench

//   Bit-serial WIDTH-bit adder/subtractor. Processes one bit per clock, LSB first.

---
 rtl/serial_addsub.sv | 127 ++++++++++++
 tb/tb_serial_addsub.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Each bit is a full adder/subtractor built from two half cells plus a carry/borrow flop.

module serial_addsub_ha (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module serial_addsub_hs (
    input  logic i_x,
    input  logic i_y,
    output logic o_d,
    output logic o_b
);
    assign o_d = i_x ^ i_y;
    assign o_b = ~i_x & i_y;
endmodule

module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_m;
    logic             r_cb;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;

    logic w_ha1_s, w_ha1_c, w_ha2_s, w_ha2_c;
    logic w_hs1_d, w_hs1_b, w_hs2_d, w_hs2_b;
    logic w_s, w_cb_next;
    logic [WIDTH-1:0] w_acc_next;

    // Cascade of two half cells: the second folds in the registered carry/borrow.
    serial_addsub_ha u_ha1 (.i_x(r_sa[0]), .i_y(r_sb[0]), .o_s(w_ha1_s), .o_c(w_ha1_c));
    serial_addsub_ha u_ha2 (.i_x(w_ha1_s), .i_y(r_cb),    .o_s(w_ha2_s), .o_c(w_ha2_c));
    serial_addsub_hs u_hs1 (.i_x(r_sa[0]), .i_y(r_sb[0]), .o_d(w_hs1_d), .o_b(w_hs1_b));
    serial_addsub_hs u_hs2 (.i_x(w_hs1_d), .i_y(r_cb),    .o_d(w_hs2_d), .o_b(w_hs2_b));

    always_comb begin
        w_s       = 1'b0;
        w_cb_next = 1'b0;
        if (r_m) begin
            w_s       = w_hs2_d;
            w_cb_next = w_hs1_b | w_hs2_b;
        end else begin
            w_s       = w_ha2_s;
            w_cb_next = w_ha1_c | w_ha2_c;
        end
    end

    // acc only keeps the WIDTH-1 bits already shifted in; the current bit completes the word.
    assign w_acc_next = {w_s, r_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_m      <= 1'b0;
            r_cb     <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_m     <= mode;
                        r_cb    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_acc <= w_acc_next[WIDTH-1:1];
                    r_cb  <= w_cb_next;
                    if (r_cnt == LAST_BIT) begin
                        r_result <= w_acc_next;
                        r_cout   <= w_cb_next;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == RUN) || (r_state == DONE);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cout   = r_cout;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboarded bench for serial_addsub at WIDTH=4 and WIDTH=8 against an arithmetic reference.

module tb_serial_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int unsigned res;
        int unsigned cout;
        int unsigned cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    logic       rst4 = 1'b1, start4 = 1'b0, mode4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, result4;
    logic       busy4, done4, cout4;

    logic       rst8 = 1'b1, start8 = 1'b0, mode8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, result8;
    logic       busy8, done8, cout8;

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4)
    );

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .cout(cout8)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic; cout is the carry out of the sum or the borrow (a<b).
    function automatic exp_t model(input int unsigned w, input int unsigned a, input int unsigned b,
                                   input bit m, input int unsigned done_cyc);
        exp_t e;
        int unsigned lim;
        lim = 1 << w;
        if (!m) begin
            e.res  = (a + b) % lim;
            e.cout = ((a + b) >= lim) ? 1 : 0;
        end else begin
            e.res  = (a + lim - b) % lim;
            e.cout = (a < b) ? 1 : 0;
        end
        e.cyc = done_cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL w4_unexpected_done: got done=1, expected 0");
            end else begin
                e = q4.pop_front();
                check("w4_result", 32'(result4), e.res);
                check("w4_cout", 32'(cout4), e.cout);
                check("w4_done_cycle", cyc, e.cyc);
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL w8_unexpected_done: got done=1, expected 0");
            end else begin
                e = q8.pop_front();
                check("w8_result", 32'(result8), e.res);
                check("w8_cout", 32'(cout8), e.cout);
                check("w8_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle4();
        int unsigned t = 0;
        while (busy4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("w4_idle_wait", 32'(busy4), 0);
    endtask

    task automatic wait_idle8();
        int unsigned t = 0;
        while (busy8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("w8_idle_wait", 32'(busy8), 0);
    endtask

    task automatic op4(input int unsigned a, input int unsigned b, input bit m);
        wait_idle4();
        a4 = 4'(a); b4 = 4'(b); mode4 = m; start4 = 1'b1;
        q4.push_back(model(4, a, b, m, cyc + 1 + 4));
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); mode4 = 1'($urandom);
    endtask

    task automatic op8(input int unsigned a, input int unsigned b, input bit m);
        wait_idle8();
        a8 = 8'(a); b8 = 8'(b); mode8 = m; start8 = 1'b1;
        q8.push_back(model(8, a, b, m, cyc + 1 + 8));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t;
        fork
            begin : w4_seq
                int unsigned c0, ha, hb;
                bit hm;
                repeat (2) @(negedge clk);
                check("w4_reset_busy", 32'(busy4), 0);
                check("w4_reset_done", 32'(done4), 0);
                check("w4_reset_result", 32'(result4), 0);
                check("w4_reset_cout", 32'(cout4), 0);
                rst4 = 1'b0;

                op4(5, 3, 0);
                op4(15, 1, 0);
                op4(3, 5, 1);
                op4(9, 9, 1);
                op4(7, 2, 1);

                op4(1, 1, 0);
                @(negedge clk);
                a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                wait_idle4();
                @(negedge clk);
                check("w4_ignored_start_no_op", 32'(busy4), 0);

                wait_idle4();
                c0 = cyc;
                ha = $urandom_range(0, 15); hb = $urandom_range(0, 15); hm = 1'($urandom);
                a4 = 4'(ha); b4 = 4'(hb); mode4 = hm; start4 = 1'b1;
                for (int i = 0; i < 3; i++)
                    q4.push_back(model(4, ha, hb, hm, c0 + 1 + 4 + 6 * i));
                while (cyc < c0 + 1 + 4 + 12) @(negedge clk);
                start4 = 1'b0;

                wait_idle4();
                a4 = 4'd6; b4 = 4'd6; mode4 = 1'b0; start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                repeat (2) @(negedge clk);
                rst4 = 1'b1;
                @(negedge clk);
                rst4 = 1'b0;
                check("w4_abort_busy", 32'(busy4), 0);
                check("w4_abort_done", 32'(done4), 0);
                check("w4_abort_result", 32'(result4), 0);
                check("w4_abort_cout", 32'(cout4), 0);
                repeat (8) @(negedge clk);
                op4(2, 2, 0);

                repeat (30) op4($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom));
                wait_idle4();
            end
            begin : w8_seq
                repeat (2) @(negedge clk);
                check("w8_reset_result", 32'(result8), 0);
                check("w8_reset_busy", 32'(busy8), 0);
                rst8 = 1'b0;
                op8(200, 100, 0);
                op8(100, 200, 1);
                op8(255, 255, 0);
                repeat (12) op8($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
                wait_idle8();
            end
        join

        t = 0;
        while ((q4.size() + q8.size()) != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drain", q4.size() + q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
